inv_deglitch_bank: RTL and testbench

Parametrised multi-channel inverter with an input synchroniser and a per-channel digital deglitch filter. It is the clocked successor to the single-bit 5V brick inverter in the step-down soft-start path. Each channel resynchronises an asynchronous comparator or enable signal, rejects pulses shorter than a programmable count, and drives an inverted or non-inverted output, selected per channel. A one-cycle change flag is provided for the soft-start sequencer.

---
 rtl/inv_deglitch_bank_pkg.sv | 14 +
 rtl/inv_deglitch_ch.sv | 49 ++++
 rtl/inv_deglitch_bank.sv | 40 ++++
 tb/tb_inv_deglitch_bank.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/inv_deglitch_bank_pkg.sv
// Shared defaults for the deglitching inverter bank.
package inv_pkg;

  localparam int unsigned INV_WIDTH_DEF  = 4;
  localparam int unsigned INV_FILT_W_DEF = 4;

  // Largest threshold the default counter width can express.
  localparam int unsigned INV_THR_MAX_DEF = (1 << INV_FILT_W_DEF) - 1;

  function automatic int unsigned inv_thr_max(input int unsigned filt_w);
    return (1 << filt_w) - 1;
  endfunction

endpackage

// File: rtl/inv_deglitch_ch.sv
// One channel: two-flop synchroniser, counting deglitch filter, change pulse
// and selectable output inversion.
module inv_deglitch_ch
  import inv_pkg::*;
#(
  parameter int unsigned FILT_W  = INV_FILT_W_DEF,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i,
  input  logic              inv_en,
  input  logic [FILT_W-1:0] thr,
  output logic              o,
  output logic              chg
);

  logic              s1;
  logic              s2;
  logic              f;
  logic [FILT_W-1:0] cnt;

  // cnt only advances while below thr, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= RST_VAL;
      s2  <= RST_VAL;
      f   <= RST_VAL;
      cnt <= '0;
      chg <= 1'b0;
    end else begin
      s1  <= i;
      s2  <= s1;
      chg <= 1'b0;
      if (s2 == f) begin
        cnt <= '0;
      end else if (cnt >= thr) begin
        f   <= s2;
        cnt <= '0;
        chg <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o = f ^ inv_en;

endmodule

// File: rtl/inv_deglitch_bank.sv
// Multi-channel synchronised, deglitched inverter/buffer bank.
module inv_deglitch_bank
  import inv_pkg::*;
#(
  parameter int unsigned WIDTH   = INV_WIDTH_DEF,
  parameter int unsigned FILT_W  = INV_FILT_W_DEF,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic              CELCLK,
  input  logic              CELRSTN,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic [WIDTH-1:0]  i,
  input  logic [WIDTH-1:0]  inv_en,
  input  logic [FILT_W-1:0] thr,
  output logic [WIDTH-1:0]  o,
  output logic [WIDTH-1:0]  chg
);

  // Supply and substrate pins carry no logic function.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    inv_deglitch_ch #(
      .FILT_W  (FILT_W),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk    (CELCLK),
      .rst_n  (CELRSTN),
      .i      (i[n]),
      .inv_en (inv_en[n]),
      .thr    (thr),
      .o      (o[n]),
      .chg    (chg[n])
    );
  end

endmodule

// File: tb/tb_inv_deglitch_bank.sv
// Self-checking bench for inv_deglitch_bank (4 channels, 4-bit filter).
module tb_inv_deglitch_bank;

  typedef struct {
    logic       rst_n;
    logic [3:0] i;
    logic [3:0] en;
    logic [3:0] thr;
    logic [3:0] eo;
    logic [3:0] ec;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] eo;
    logic [3:0] ec;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i, inv_en, thr, o, chg;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  inv_deglitch_bank #(
    .WIDTH   (4),
    .FILT_W  (4),
    .RST_VAL (1'b0)
  ) dut (
    .CELCLK  (clk),
    .CELRSTN (rst_n),
    .CELV    (1'b1),
    .CELG    (1'b0),
    .SUB     (1'b0),
    .i       (i),
    .inv_en  (inv_en),
    .thr     (thr),
    .o       (o),
    .chg     (chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic void add(input string tag, input logic r, input logic [3:0] iv,
                              input logic [3:0] en, input logic [3:0] th, input int e,
                              input logic [3:0] eo, input logic [3:0] ec);
    vec_t v;
    v.rst_n = r; v.i = iv; v.en = en; v.thr = th; v.eo = eo; v.ec = ec;
    v.name = $sformatf("%s E%0d", tag, e);
    vecs.push_back(v);
  endfunction

  function automatic void add_n(input string tag, input logic r, input logic [3:0] iv,
                                input logic [3:0] en, input logic [3:0] th, input int e0,
                                input int n, input logic [3:0] eo, input logic [3:0] ec);
    for (int k = 0; k < n; k++) add(tag, r, iv, en, th, e0 + k, eo, ec);
  endfunction

  // Drive one row away from the active edge and queue what the next edge must produce.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; i = v.i; inv_en = v.en; thr = v.thr;
    e.eo = v.eo; e.ec = v.ec; e.name = v.name;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, " o"}, o, e.eo);
        chk({e.name, " chg"}, chg, e.ec);
      end
    end
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; i = 4'b0000; inv_en = 4'b0101; thr = 4'd0;

    add_n("post rst", 1'b1, 4'b0000, 4'b0101, 4'd0, 1, 2, 4'b0101, 4'b0000);
    add_n("thr0 up",  1'b1, 4'b0001, 4'b0101, 4'd0, 1, 2, 4'b0101, 4'b0000);
    add  ("thr0 up",  1'b1, 4'b0001, 4'b0101, 4'd0, 3,    4'b0100, 4'b0001);
    add  ("thr0 up",  1'b1, 4'b0001, 4'b0101, 4'd0, 4,    4'b0100, 4'b0000);
    add_n("thr0 dn",  1'b1, 4'b0000, 4'b0101, 4'd0, 1, 2, 4'b0100, 4'b0000);
    add  ("thr0 dn",  1'b1, 4'b0000, 4'b0101, 4'd0, 3,    4'b0101, 4'b0001);
    add  ("thr0 dn",  1'b1, 4'b0000, 4'b0101, 4'd0, 4,    4'b0101, 4'b0000);
    add_n("thr3 rej", 1'b1, 4'b0010, 4'b0101, 4'd3, 1, 3, 4'b0101, 4'b0000);
    add_n("thr3 rej", 1'b1, 4'b0000, 4'b0101, 4'd3, 4, 5, 4'b0101, 4'b0000);
    add_n("thr3 acc", 1'b1, 4'b0010, 4'b0101, 4'd3, 1, 4, 4'b0101, 4'b0000);
    add  ("thr3 acc", 1'b1, 4'b0000, 4'b0101, 4'd3, 5,    4'b0101, 4'b0000);
    add  ("thr3 acc", 1'b1, 4'b0000, 4'b0101, 4'd3, 6,    4'b0111, 4'b0010);
    add_n("thr3 acc", 1'b1, 4'b0000, 4'b0101, 4'd3, 7, 3, 4'b0111, 4'b0000);
    add  ("thr3 acc", 1'b1, 4'b0000, 4'b0101, 4'd3, 10,   4'b0101, 4'b0010);
    add  ("thr3 acc", 1'b1, 4'b0000, 4'b0101, 4'd3, 11,   4'b0101, 4'b0000);
    add_n("thr lower", 1'b1, 4'b1000, 4'b0101, 4'd5, 1, 5, 4'b0101, 4'b0000);
    add  ("thr lower", 1'b1, 4'b1000, 4'b0101, 4'd1, 6,    4'b1101, 4'b1000);
    add  ("thr lower", 1'b1, 4'b1000, 4'b0101, 4'd1, 7,    4'b1101, 4'b0000);
    add_n("thr1 dn",  1'b1, 4'b0000, 4'b0101, 4'd1, 1, 3, 4'b1101, 4'b0000);
    add  ("thr1 dn",  1'b1, 4'b0000, 4'b0101, 4'd1, 4,    4'b0101, 4'b1000);
    add  ("thr1 dn",  1'b1, 4'b0000, 4'b0101, 4'd1, 5,    4'b0101, 4'b0000);
    add_n("all up",   1'b1, 4'b1111, 4'b0101, 4'd5, 1, 7, 4'b0101, 4'b0000);
    add  ("all up",   1'b1, 4'b1111, 4'b0101, 4'd5, 8,    4'b1010, 4'b1111);
    add  ("all up",   1'b1, 4'b1111, 4'b0101, 4'd5, 9,    4'b1010, 4'b0000);
    add_n("all dn",   1'b1, 4'b0000, 4'b0101, 4'd0, 1, 2, 4'b1010, 4'b0000);
    add  ("all dn",   1'b1, 4'b0000, 4'b0101, 4'd0, 3,    4'b0101, 4'b1111);
    add  ("all dn",   1'b1, 4'b0000, 4'b0101, 4'd0, 4,    4'b0101, 4'b0000);
    add_n("rst mid",  1'b1, 4'b0001, 4'b0101, 4'd7, 1, 6, 4'b0101, 4'b0000);
    add_n("rst low",  1'b0, 4'b0001, 4'b0101, 4'd7, 1, 2, 4'b0101, 4'b0000);
    add_n("rst rel",  1'b1, 4'b0001, 4'b0101, 4'd7, 1, 9, 4'b0101, 4'b0000);
    add  ("rst rel",  1'b1, 4'b0001, 4'b0101, 4'd7, 10,   4'b0100, 4'b0001);
    add  ("rst rel",  1'b1, 4'b0001, 4'b0101, 4'd7, 11,   4'b0100, 4'b0000);

    repeat (2) @(negedge clk);
    chk("reset o", o, 4'b0101);
    chk("reset chg", chg, 4'b0000);

    foreach (vecs[k]) apply(vecs[k]);

    // Mode toggle on channel 2 with all inputs static (f = 4'b0001 here).
    @(negedge clk);
    inv_en = 4'b0001;
    #1;
    chk("mode comb o", o, 4'b0000);
    chk("mode comb chg", chg, 4'b0000);
    v.rst_n = 1'b1; v.i = 4'b0001; v.en = 4'b0001; v.thr = 4'd7;
    v.eo = 4'b0000; v.ec = 4'b0000; v.name = "mode hold";
    apply(v);
    apply(v);
    @(negedge clk);
    inv_en = 4'b0101;
    #1;
    chk("mode back o", o, 4'b0100);
    v.en = 4'b0101; v.eo = 4'b0100; v.name = "mode back";
    apply(v);

    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
